// File: rtl/led_cube_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_cube_scan_sequencer
// Purpose  : Layer-multiplexed refresh engine for an 8x8x8 LED cube. Each
//            layer is blanked, its eight row latches are loaded one by one
//            over the shared data bus, and the layer is then lit. Frame data
//            comes from a double-buffered 2x64-byte store. Back/front swaps
//            happen only at frame boundaries, so a frame never tears.
// Ports    : clk_clk        - system clock
//            reset_reset_n  - asynchronous active-low reset
//            enable         - scanning enabled
//            wr_en/wr_addr/wr_data - byte write into the back bank,
//                             wr_addr = {layer, row}, wr_data bit i = column i
//            commit         - request a bank swap at the next frame end
//            commit_ack     - 1-cycle pulse when a swap takes effect
//            layers_out     - one-hot layer enable
//            latches_out    - one-hot row latch clock
//            data_out       - shared row data bus
//            cur_layer      - layer currently being loaded or lit
//            frame_done     - 1-cycle pulse after layer 7 ON completes
// Revision : 1.0 - initial release
// ============================================================================
module led_cube_scan_sequencer #(
    parameter int DEAD_CYCLES  = 50,
    parameter int SETUP_CYCLES = 2,
    parameter int LATCH_CYCLES = 4,
    parameter int ON_CYCLES    = 5000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    output logic       commit_ack,
    output logic [7:0] layers_out,
    output logic [7:0] latches_out,
    output logic [7:0] data_out,
    output logic [2:0] cur_layer,
    output logic       frame_done
);

    // Down-counter sized for the longest phase; it is loaded with length-1.
    localparam int c_MAX_AB = (DEAD_CYCLES > SETUP_CYCLES) ? DEAD_CYCLES : SETUP_CYCLES;
    localparam int c_MAX_CD = (LATCH_CYCLES > ON_CYCLES) ? LATCH_CYCLES : ON_CYCLES;
    localparam int c_MAXC   = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
    localparam int c_CW     = (c_MAXC > 1) ? $clog2(c_MAXC) : 1;

    localparam logic [c_CW-1:0] c_DEAD_LD  = c_CW'(DEAD_CYCLES - 1);
    localparam logic [c_CW-1:0] c_SETUP_LD = c_CW'(SETUP_CYCLES - 1);
    localparam logic [c_CW-1:0] c_LATCH_LD = c_CW'(LATCH_CYCLES - 1);
    localparam logic [c_CW-1:0] c_ON_LD    = c_CW'(ON_CYCLES - 1);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_BLANK = 3'd1;
    localparam logic [2:0] c_ST_SETUP = 3'd2;
    localparam logic [2:0] c_ST_LATCH = 3'd3;
    localparam logic [2:0] c_ST_HOLD  = 3'd4;
    localparam logic [2:0] c_ST_ON    = 3'd5;

    logic [2:0]      r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_layer, w_layer_nxt;
    logic [2:0]      r_row, w_row_nxt;
    logic            w_frame_end;
    logic            w_swap;
    logic            r_front;
    logic            r_pend;
    logic [7:0]      w_rd_data;
    logic [7:0]      w_layers_d, w_latches_d, w_data_d;

    // Both banks in one array, indexed {bank, layer, row}. Not reset: the
    // frame content survives a reset.
    logic [7:0] r_bank [0:127];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_layer <= 3'd0;
            r_row   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_layer <= w_layer_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_layer_nxt = r_layer;
        w_row_nxt   = r_row;
        w_frame_end = 1'b0;
        if (r_state != c_ST_IDLE && !enable) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
            w_layer_nxt = 3'd0;
            w_row_nxt   = 3'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (enable) begin
                        w_state_nxt = c_ST_BLANK;
                        w_cnt_nxt   = c_DEAD_LD;
                        w_layer_nxt = 3'd0;
                        w_row_nxt   = 3'd0;
                    end
                end
                c_ST_BLANK: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = c_ST_SETUP;
                        w_cnt_nxt   = c_SETUP_LD;
                    end else begin
                        w_cnt_nxt = r_cnt - c_ONE;
                    end
                end
                c_ST_SETUP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = c_ST_LATCH;
                        w_cnt_nxt   = c_LATCH_LD;
                    end else begin
                        w_cnt_nxt = r_cnt - c_ONE;
                    end
                end
                c_ST_LATCH: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = c_ST_HOLD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_ONE;
                    end
                end
                c_ST_HOLD: begin
                    if (r_row != 3'd7) begin
                        w_row_nxt   = r_row + 3'd1;
                        w_state_nxt = c_ST_SETUP;
                        w_cnt_nxt   = c_SETUP_LD;
                    end else begin
                        w_state_nxt = c_ST_ON;
                        w_cnt_nxt   = c_ON_LD;
                    end
                end
                c_ST_ON: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = c_ST_BLANK;
                        w_cnt_nxt   = c_DEAD_LD;
                        w_layer_nxt = r_layer + 3'd1;   // 7 wraps to 0
                        w_row_nxt   = 3'd0;
                        w_frame_end = (r_layer == 3'd7);
                    end else begin
                        w_cnt_nxt = r_cnt - c_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_layer_nxt = 3'd0;
                    w_row_nxt   = 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: computed from the next state so that the registered
    // outputs line up with the state they describe.
    // ------------------------------------------------------------------
    assign w_rd_data = r_bank[{r_front, w_layer_nxt, w_row_nxt}];
    assign w_swap    = w_frame_end & r_pend;

    always_comb begin
        w_layers_d  = 8'h00;
        w_latches_d = 8'h00;
        w_data_d    = data_out;
        if (w_state_nxt == c_ST_ON) begin
            w_layers_d = 8'd1 << w_layer_nxt;
        end
        if (w_state_nxt == c_ST_LATCH) begin
            w_latches_d = 8'd1 << w_row_nxt;
        end
        // The bus is reloaded only when entering SETUP; it stays put through
        // LATCH, HOLD, ON and BLANK.
        if (w_state_nxt == c_ST_IDLE) begin
            w_data_d = 8'h00;
        end else if (w_state_nxt == c_ST_SETUP && r_state != c_ST_SETUP) begin
            w_data_d = w_rd_data;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            layers_out  <= 8'h00;
            latches_out <= 8'h00;
            data_out    <= 8'h00;
            cur_layer   <= 3'd0;
            frame_done  <= 1'b0;
            commit_ack  <= 1'b0;
        end else begin
            layers_out  <= w_layers_d;
            latches_out <= w_latches_d;
            data_out    <= w_data_d;
            cur_layer   <= w_layer_nxt;
            frame_done  <= w_frame_end;
            commit_ack  <= w_swap;
        end
    end

    // ------------------------------------------------------------------
    // Bank control. A commit on the swap edge becomes the next pending
    // request instead of being lost in the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_front <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_front <= r_front ^ w_swap;
            r_pend  <= w_swap ? commit : (r_pend | commit);
        end
    end

    // Writes use the pre-swap back bank, which becomes front on a swap edge.
    always_ff @(posedge clk_clk) begin
        if (wr_en) begin
            r_bank[{~r_front, wr_addr}] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_cube_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_cube_scan_sequencer
// Purpose  : Self-checking bench for led_cube_scan_sequencer. A reference
//            model tracks the frame position arithmetically and pushes every
//            expected visible event (latch pulse, lit layer, frame end) into
//            a queue; a monitor pops one entry per observed event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_cube_scan_sequencer;

    localparam int DEAD  = 2;
    localparam int SETUP = 1;
    localparam int LATCH = 1;
    localparam int ON    = 4;
    localparam int RS    = SETUP + LATCH + 1;       // cycles per row load
    localparam int LAYER = DEAD + 8 * RS + ON;      // 30
    localparam int FRAME = 8 * LAYER;               // 240

    logic       clk = 1'b0;
    logic       rst_n, enable, wr_en, commit;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit_ack, frame_done;
    logic [7:0] layers_out, latches_out, data_out;
    logic [2:0] cur_layer;

    always #5 clk = ~clk;

    led_cube_scan_sequencer #(
        .DEAD_CYCLES (DEAD),
        .SETUP_CYCLES(SETUP),
        .LATCH_CYCLES(LATCH),
        .ON_CYCLES   (ON)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .enable       (enable),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit       (commit),
        .commit_ack   (commit_ack),
        .layers_out   (layers_out),
        .latches_out  (latches_out),
        .data_out     (data_out),
        .cur_layer    (cur_layer),
        .frame_done   (frame_done)
    );

    typedef struct {
        int         cyc;
        logic [7:0] layers;
        logic [7:0] latches;
        logic [7:0] data;
        logic [2:0] cur;
        logic       fd;
        logic       ack;
        logic       chk;
    } ev_t;

    ev_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;

    // Reference model state: scanning flag, position in frame, banks.
    bit         m_active = 1'b0;
    int         m_p      = 0;
    bit         m_fr     = 1'b0;
    bit         m_pend   = 1'b0;
    logic [7:0] m_bank  [2][64];
    bit         m_known [2][64];

    task automatic model_reset();
        m_active = 1'b0;
        m_p      = 0;
        m_fr     = 1'b0;
        m_pend   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit  fe, ack;
        int  bk, l, q, r, ph;
        ev_t e;
        cyc++;
        fe  = m_active && enable && (m_p == FRAME - 1);
        ack = fe && m_pend;
        if (wr_en) begin
            bk = m_fr ? 0 : 1;
            m_bank[bk][wr_addr]  = wr_data;
            m_known[bk][wr_addr] = 1'b1;
        end
        if (ack) begin
            m_fr   = !m_fr;
            m_pend = commit;
        end else if (commit) begin
            m_pend = 1'b1;
        end
        if (m_active) begin
            if (!enable) m_active = 1'b0;
            else         m_p = (m_p + 1) % FRAME;
        end else if (enable) begin
            m_active = 1'b1;
            m_p      = 0;
        end
        if (fe) begin
            e.cyc = cyc; e.layers = 8'h00; e.latches = 8'h00; e.data = 8'h00;
            e.cur = 3'd0; e.fd = 1'b1; e.ack = ack; e.chk = 1'b0;
            exp_q.push_back(e);
        end
        if (m_active) begin
            bk = m_fr ? 1 : 0;
            l  = m_p / LAYER;
            q  = m_p % LAYER;
            e.cyc = cyc; e.cur = 3'(l); e.fd = 1'b0; e.ack = 1'b0;
            if (q >= DEAD && q < DEAD + 8 * RS) begin
                r  = (q - DEAD) / RS;
                ph = (q - DEAD) % RS;
                if (ph >= SETUP && ph < SETUP + LATCH) begin
                    e.layers  = 8'h00;
                    e.latches = 8'(1 << r);
                    e.data    = m_bank[bk][l * 8 + r];
                    e.chk     = m_known[bk][l * 8 + r];
                    exp_q.push_back(e);
                end
            end else if (q >= DEAD + 8 * RS) begin
                e.layers  = 8'(1 << l);
                e.latches = 8'h00;
                e.data    = m_bank[bk][l * 8 + 7];
                e.chk     = m_known[bk][l * 8 + 7];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic mon_step();
        ev_t e;
        if (rst_n && (layers_out != 8'h00 || latches_out != 8'h00 || frame_done || commit_ack)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event cyc=%0d got layers=%h latches=%h fd=%b ack=%b, required no event",
                         cyc, layers_out, latches_out, frame_done, commit_ack);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || layers_out !== e.layers || latches_out !== e.latches ||
                    frame_done !== e.fd || commit_ack !== e.ack || cur_layer !== e.cur ||
                    (e.chk && data_out !== e.data)) begin
                    miscompares++;
                    $display("FAIL scan_event cyc=%0d got layers=%h latches=%h data=%h cur=%0d fd=%b ack=%b; required cyc=%0d layers=%h latches=%h data=%h(chk=%b) cur=%0d fd=%b ack=%b",
                             cyc, layers_out, latches_out, data_out, cur_layer, frame_done, commit_ack,
                             e.cyc, e.layers, e.latches, e.data, e.chk, e.cur, e.fd, e.ack);
                end
            end
        end
    endtask

    task automatic chk_zero(input string name);
        vectors++;
        if (layers_out !== 8'h00 || latches_out !== 8'h00 || data_out !== 8'h00 ||
            cur_layer !== 3'd0 || frame_done !== 1'b0 || commit_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL %s got layers=%h latches=%h data=%h cur=%0d fd=%b ack=%b, required all zero",
                     name, layers_out, latches_out, data_out, cur_layer, frame_done, commit_ack);
        end
    endtask

    task automatic wait_p(input int target, input int budget);
        int n = 0;
        while (!(m_active && m_p == target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_position got timeout after %0d cycles, required position %0d", n, target);
        end
    endtask

    task automatic wr_byte(input logic [5:0] a, input logic [7:0] d, input logic c);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        commit  = c;
        @(negedge clk);
        wr_en   = 1'b0;
        commit  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; wr_en = 1'b0; commit = 1'b0;
        wr_addr = 6'd0; wr_data = 8'h00;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) model_reset();
                else        model_step();
            end
        join_none

        #2 rst_n = 1'b0;
        #1 chk_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_outputs");
        enable = 1'b1;

        // Frame 0: fill back bank with zeros plus one marked byte, commit.
        for (int a = 0; a < 64; a++) wr_byte(6'(a), 8'h00, 1'b0);
        wr_byte({3'd3, 3'd5}, 8'hA5, 1'b1);
        wait_p(FRAME - 1, 2 * FRAME);
        @(negedge clk);

        // Frame 1: random fill of the new back bank, three commits.
        for (int a = 0; a < 64; a++)
            wr_byte(6'(a), 8'($urandom_range(255)), (a == 5 || a == 20 || a == 40));
        wait_p(FRAME - 1, 2 * FRAME);
        @(negedge clk);

        // Frame 2: random writes, no commit -> no ack at its end.
        for (int i = 0; i < 12; i++)
            wr_byte(6'($urandom_range(63)), 8'($urandom_range(255)), 1'b0);
        wait_p(FRAME - 1, 2 * FRAME);
        @(negedge clk);

        // Frame 3: writes and a commit; then commit + write on the swap edge.
        for (int i = 0; i < 12; i++)
            wr_byte(6'($urandom_range(63)), 8'($urandom_range(255)), (i == 11));
        wait_p(FRAME - 1, 2 * FRAME);
        wr_byte(6'd0, 8'hFF, 1'b1);

        // Frame 4: drop enable during layer 4 ON, then re-enable.
        wait_p(4 * LAYER + DEAD + 8 * RS, 2 * FRAME);
        enable = 1'b0;
        @(negedge clk);
        chk_zero("enable_low_outputs");
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        wait_p(FRAME - 1, 2 * FRAME);
        @(negedge clk);

        // Async reset pulse between edges during a latch pulse.
        wait_p(2 * LAYER + DEAD + 4 * RS + SETUP, 2 * FRAME);
        #1 rst_n = 1'b0;
        #1 chk_zero("async_reset_outputs");
        #1 rst_n = 1'b1;
        @(negedge clk);
        wait_p(FRAME - 1, 2 * FRAME);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events got %0d unobserved, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_cube_scan_sequencer.md
Name: led_cube_scan_sequencer

Overview:
- Drives the 8x8x8 LED cube's shared 8-bit data bus, 8 row-latch clocks and 8 layer enables from a double-buffered 512-bit frame store.
- Performs layer-multiplexed refresh: blank, load 8 row latches, then enable one layer.
- Sits between the UART command logic (frame writer) and the GPIO pin mapping (Layers/Latches/Data).
- Frame swaps occur only at frame boundaries, so the display never tears.

Parameters:
- DEAD_CYCLES, 50: cycles with all layers off before loading a layer (ghosting guard); must be >=1.
- SETUP_CYCLES, 2: cycles data_out is held before a latch pulse; must be >=1.
- LATCH_CYCLES, 4: width of each latch-clock high pulse; must be >=1.
- ON_CYCLES, 5000: cycles the loaded layer is lit; must be >=1.

Ports:
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset_n  in  1  asynchronous active-low reset.
- enable  in  1  scanning enabled.
- wr_en  in  1  write one byte to the back buffer.
- wr_addr  in  6  {layer[2:0], row[2:0]}.
- wr_data  in  8  row bit pattern; bit i = column i.
- commit  in  1  request back/front swap at the next frame end.
- commit_ack  out  1  1-cycle pulse when a swap takes effect.
- layers_out  out  8  one-hot layer enable, active high.
- latches_out  out  8  one-hot row latch clock, active high.
- data_out  out  8  shared row data bus.
- cur_layer  out  3  layer currently being loaded or lit.
- frame_done  out  1  1-cycle pulse at the end of layer 7 ON.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - The front buffer is bank 0, commit_pending=0, and the FSM is in IDLE.
  - Buffer contents are not cleared.
- FSM states: IDLE, BLANK, SETUP, LATCH, HOLD, ON.
  - IDLE: outputs 0. Goes to BLANK (layer 0, row 0) when enable=1.
  - BLANK: layers_out=0, latches_out=0, lasts DEAD_CYCLES cycles, then goes to SETUP.
  - SETUP: data_out = front[layer][row], held constant for SETUP_CYCLES cycles, then goes to LATCH. data_out may change only on entry to SETUP.
  - LATCH: latches_out = 1<<row for LATCH_CYCLES cycles; data_out is unchanged. Then goes to HOLD.
  - HOLD: latches_out=0 and data_out is unchanged for 1 cycle. If row<7, increment row and go to SETUP; otherwise go to ON.
  - ON: layers_out = 1<<layer for ON_CYCLES cycles.
    - On the last cycle, if layer<7: layer+1, row=0, go to BLANK.
    - If layer==7: frame_done pulses next cycle, layer wraps to 0, go to BLANK.
- Layer period = DEAD + 8*(SETUP+LATCH+1) + ON cycles. Frame period = 8 layer periods.
- Invariants:
  - layers_out and latches_out are never simultaneously non-zero.
  - Each is at most one-hot.
  - All outputs are registered (glitch-free).
- Buffer:
  - There are two 64x8 banks. Writes go only to the back bank; writes are never rejected or stalled.
  - commit sets commit_pending; repeated commits while pending are absorbed.
  - At frame end (same edge frame_done asserts), if pending: swap banks, clear pending, and pulse commit_ack together with frame_done.
  - A commit arriving on the swap edge is recorded as a new pending request.
  - A wr_en on the swap edge writes the pre-swap back bank, so the byte becomes visible in the new frame.
  - After a swap the new back bank holds stale content; the writer rewrites the full frame.
- enable deasserted mid-scan:
  - Outputs go to 0 on the next edge and the FSM goes to IDLE.
  - layer and row reset to 0, and the pending commit is kept.
  - Re-enable restarts at layer 0 via BLANK.
- Async reset mid-operation: outputs go to 0 immediately (no clock needed).

Test Plan (DEAD=2, SETUP=1, LATCH=1, ON=4; layer period 30, frame 240):
- Reset, enable=1, front all 0 -> latches_out pulses 01,02,...,80 (one cycle each, 3 apart); layers_out=01 for 4 cycles, then 02; frame_done every 240 cycles; layers_out and latches_out are never both non-zero.
- Write back[layer3,row5]=A5, commit at cycle 10 -> no change in frame 0; commit_ack and frame_done coincide at cycle 240; in frame 1, data_out=A5 during the latches_out=20 pulse of layer 3, and data_out=00 elsewhere.
- Three commits during one frame -> exactly one commit_ack at frame end, and none at the following frame end.
- Commit and wr_en(addr 0, FF) asserted on the swap edge -> swap occurs; layer0 row0 shows FF in the next frame; commit_ack fires again at the frame after.
- enable low during layer 4 ON -> all outputs 0 next cycle; re-enable -> 2 BLANK cycles, then the latch sequence restarts at layer 0, row 0.
- reset_reset_n pulsed low between clock edges during LATCH -> latches_out=0 immediately, before the next edge; after release, the front buffer is bank 0.
